// File: rtl/computer_run_ctrl.sv
// Run controller: holds the processor in reset until the host supplies a start
// address, times the boot window, then counts interrupt requests against host acks.
module computer_run_ctrl #(
    parameter int unsigned BOOT_CYCLES = 16,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_start_ready,
    input  logic [31:0]       mem_start,
    input  logic              interrupt_ack,
    input  logic              cpu_interrupt_req,
    output logic              cpu_reset,
    output logic [31:0]       cpu_mem_start,
    output logic              cpu_interrupt_ack,
    output logic              irq,
    output logic              running,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    // state | meaning
    // IDLE  | processor held in reset, waiting for a start address
    // BOOT  | address latched, processor held while boot counter runs down
    // RUN   | processor released, interrupts counted; left only by reset
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [15:0]       BOOT_LOAD = 16'(BOOT_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            r_state;
    logic [15:0]       r_boot_cnt;
    logic              r_cpu_reset;
    logic [31:0]       r_cpu_mem_start;
    logic              r_cpu_int_ack;
    logic              r_irq;
    logic              r_running;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;

    logic [PEND_W-1:0] w_pend_next;
    logic              w_ack_fire;
    logic              w_drop;

    // An ack is applied before a simultaneous request, so a lone ack at zero is lost.
    always_comb begin
        w_pend_next = r_pending;
        w_ack_fire  = 1'b0;
        w_drop      = 1'b0;
        if (r_state == ST_RUN) begin
            case ({cpu_interrupt_req, interrupt_ack})
                2'b10: begin
                    if (r_pending == PEND_MAX) w_drop = 1'b1;
                    else                       w_pend_next = r_pending + PEND_ONE;
                end
                2'b01: begin
                    if (r_pending != '0) begin
                        w_pend_next = r_pending - PEND_ONE;
                        w_ack_fire  = 1'b1;
                    end
                end
                2'b11: begin
                    if (r_pending != '0) w_ack_fire  = 1'b1;
                    else                 w_pend_next = PEND_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_boot_cnt      <= '0;
            r_cpu_reset     <= 1'b1;
            r_cpu_mem_start <= '0;
            r_cpu_int_ack   <= 1'b0;
            r_irq           <= 1'b0;
            r_running       <= 1'b0;
            r_pending       <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_cpu_int_ack <= w_ack_fire;
            r_pending     <= w_pend_next;
            r_irq         <= (w_pend_next != '0);
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (mem_start_ready) begin
                        r_cpu_mem_start <= mem_start;
                        r_boot_cnt      <= BOOT_LOAD;
                        r_state         <= ST_BOOT;
                    end
                end
                ST_BOOT: begin
                    if (r_boot_cnt == '0) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt - 16'd1;
                    end
                end
                ST_RUN:  ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_reset         = r_cpu_reset;
    assign cpu_mem_start     = r_cpu_mem_start;
    assign cpu_interrupt_ack = r_cpu_int_ack;
    assign irq               = r_irq;
    assign running           = r_running;
    assign pending           = r_pending;
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_computer_run_ctrl.sv
// Directed bench for computer_run_ctrl: boot timing, interrupt counting table,
// saturation, and asynchronous reset in each phase.
module tb_computer_run_ctrl;

    logic        clk;
    logic        resetn;
    logic        mem_start_ready;
    logic [31:0] mem_start;
    logic        interrupt_ack;
    logic        cpu_interrupt_req;
    logic        cpu_reset;
    logic [31:0] cpu_mem_start;
    logic        cpu_interrupt_ack;
    logic        irq;
    logic        running;
    logic [3:0]  pending;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    computer_run_ctrl #(.BOOT_CYCLES(16), .PEND_W(4)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_start_ready   (mem_start_ready),
        .mem_start         (mem_start),
        .interrupt_ack     (interrupt_ack),
        .cpu_interrupt_req (cpu_interrupt_req),
        .cpu_reset         (cpu_reset),
        .cpu_mem_start     (cpu_mem_start),
        .cpu_interrupt_ack (cpu_interrupt_ack),
        .irq               (irq),
        .running           (running),
        .pending           (pending),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       ack;
        logic [3:0] pend;
        logic       irq;
        logic       ack_o;
        logic       ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the following negedge with outputs of that edge.
    task automatic drive_cycle(input logic r, input logic a);
        cpu_interrupt_req = r;
        interrupt_ack     = a;
        @(negedge clk);
        cpu_interrupt_req = 1'b0;
        interrupt_ack     = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " cpu_reset"},     32'(cpu_reset), 32'd1);
        check({tag, " cpu_mem_start"}, cpu_mem_start, 32'h0);
        check({tag, " cpu_int_ack"},   32'(cpu_interrupt_ack), 32'd0);
        check({tag, " irq"},           32'(irq), 32'd0);
        check({tag, " running"},       32'(running), 32'd0);
        check({tag, " pending"},       32'(pending), 32'd0);
        check({tag, " overflow"},      32'(overflow), 32'd0);
    endtask

    // Starts from a negedge in IDLE with ready asserted; checks the 17-cycle boot window.
    task automatic boot_and_check(input string tag, input logic [31:0] addr, input bit irq_noise);
        mem_start_ready = 1'b1;
        mem_start       = addr;
        for (int k = 1; k <= 17; k++) begin
            cpu_interrupt_req = irq_noise && (k >= 2) && (k <= 6);
            interrupt_ack     = irq_noise && (k >= 3) && (k <= 7);
            @(negedge clk);
            cpu_interrupt_req = 1'b0;
            interrupt_ack     = 1'b0;
            check({tag, " cpu_reset"}, 32'(cpu_reset), (k < 17) ? 32'd1 : 32'd0);
            check({tag, " running"},   32'(running),   (k >= 17) ? 32'd1 : 32'd0);
            if (irq_noise) begin
                check({tag, " boot pending"}, 32'(pending), 32'd0);
                check({tag, " boot ack"},     32'(cpu_interrupt_ack), 32'd0);
            end
        end
        check({tag, " cpu_mem_start"}, cpu_mem_start, addr);
    endtask

    initial begin
        // Main interrupt table, starting in RUN with pending=0.
        vecs[0]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        resetn            = 1'b0;
        mem_start_ready   = 1'b1;
        mem_start         = 32'h0010_0000;
        interrupt_ack     = 1'b0;
        cpu_interrupt_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");

        resetn = 1'b1;
        boot_and_check("boot1", 32'h0010_0000, 1'b1);

        mem_start = 32'hDEAD_BEEF;
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0);
        check("addr hold", cpu_mem_start, 32'h0010_0000);

        for (int i = 0; i < 14; i++) begin
            drive_cycle(vecs[i].req, vecs[i].ack);
            check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].pend));
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].irq));
            check($sformatf("vec%0d cpu_int_ack", i), 32'(cpu_interrupt_ack), 32'(vecs[i].ack_o));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 1'b0);
            check($sformatf("sat%0d pending", i), 32'(pending), (i < 15) ? 32'(i + 1) : 32'd15);
            check($sformatf("sat%0d overflow", i), 32'(overflow), (i == 15) ? 32'd1 : 32'd0);
        end
        drive_cycle(1'b0, 1'b1);
        check("sat ack pending", 32'(pending), 32'd14);
        check("sat ack pulse", 32'(cpu_interrupt_ack), 32'd1);
        check("sat sticky ovf", 32'(overflow), 32'd1);
        drive_cycle(1'b0, 1'b0);
        check("sat pulse end", 32'(cpu_interrupt_ack), 32'd0);
        check("sat sticky ovf2", 32'(overflow), 32'd1);

        // Asynchronous reset mid-RUN, sampled between clock edges.
        #2 resetn = 1'b0;
        #1 check_reset_vals("rst run");
        mem_start_ready = 1'b0;
        mem_start       = 32'h0000_2000;
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0);
            check("idle hold reset", 32'(cpu_reset), 32'd1);
            check("idle no addr", cpu_mem_start, 32'h0);
            check("idle pending", 32'(pending), 32'd0);
        end

        // Start again and reset with the boot counter at 5 (eleven edges into BOOT).
        mem_start_ready = 1'b1;
        for (int k = 0; k < 11; k++) drive_cycle(1'b0, 1'b0);
        check("mid boot addr", cpu_mem_start, 32'h0000_2000);
        check("mid boot reset", 32'(cpu_reset), 32'd1);
        check("mid boot cnt", 32'(dut.r_boot_cnt), 32'd5);
        #2 resetn = 1'b0;
        #1 check_reset_vals("rst boot");
        mem_start_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        drive_cycle(1'b1, 1'b1);
        check("post rst idle", 32'(cpu_reset), 32'd1);
        check("post rst pend", 32'(pending), 32'd0);

        boot_and_check("boot2", 32'h0030_0000, 1'b1);
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b0);
        check("run3 pending", 32'(pending), 32'd3);
        check("run3 irq", 32'(irq), 32'd1);
        #2 resetn = 1'b0;
        #1 check_reset_vals("rst run3");
        @(negedge clk);
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
